// File: rtl/gpu_copy_segment_walker.sv
// rtl/gpu_copy_segment_walker.sv - VRAM rectangle source-read segment sequencer
module gpu_copy_segment_walker #(
    parameter int SEG_XBITS = 6,
    parameter int LINE_BITS = 9
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [SEG_XBITS+3:0]   i_x0,
    input  logic [LINE_BITS-1:0]   i_y0,
    input  logic [SEG_XBITS+4:0]   i_w,
    input  logic [LINE_BITS:0]     i_h,
    output logic                   o_busy,
    output logic                   o_reqValid,
    input  logic                   i_reqReady,
    output logic [SEG_XBITS-1:0]   o_reqSegX,
    output logic [LINE_BITS-1:0]   o_reqLine,
    output logic [15:0]            o_reqMask,
    output logic                   o_firstSeg,
    output logic                   o_lastSeg,
    output logic                   o_lastLine,
    output logic                   o_done
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t                 state;
    logic [3:0]             x0Lo;
    logic [SEG_XBITS-1:0]   segBase;
    logic [LINE_BITS-1:0]   y0Reg;
    logic [SEG_XBITS+4:0]   wReg;
    logic [LINE_BITS-1:0]   hM1;
    logic [SEG_XBITS:0]     lenHM1;
    logic [3:0]             rightPos;
    logic [SEG_XBITS:0]     segIdx;
    logic [LINE_BITS-1:0]   lineIdx;

    logic [SEG_XBITS+4:0]   spanSum;
    logic [SEG_XBITS:0]     lenSetup;
    logic [3:0]             rightSetup;
    logic [SEG_XBITS:0]     curLen;
    logic [3:0]             curRight;
    logic [SEG_XBITS:0]     nSeg;
    logic [LINE_BITS-1:0]   nLine;
    logic                   finalSeg;
    logic [15:0]            maskLeft;
    logic [15:0]            maskRight;
    logic [15:0]            nMask;
    logic                   handshake;

    // spanSum = x0Lo + w + 15; its low nibble is rightPos - 1, so rightPos falls out for free.
    assign spanSum    = {{(SEG_XBITS+1){1'b0}}, x0Lo} + wReg + (SEG_XBITS+5)'(15);
    assign lenSetup   = spanSum[SEG_XBITS+4:4] - (SEG_XBITS+1)'(1);
    assign rightSetup = spanSum[3:0] + 4'd1;

    assign handshake  = o_reqValid && i_reqReady;

    always_comb begin
        curLen   = (state == SETUP) ? lenSetup : lenHM1;
        curRight = (state == SETUP) ? rightSetup : rightPos;
        finalSeg = (segIdx == lenHM1) && (lineIdx == hM1);
        nSeg     = '0;
        nLine    = lineIdx;
        if (state == SETUP) begin
            nLine = '0;
        end else if (segIdx != lenHM1) begin
            nSeg = segIdx + (SEG_XBITS+1)'(1);
        end else begin
            nLine = lineIdx + LINE_BITS'(1);
        end
        maskLeft  = 16'hFFFF << x0Lo;
        maskRight = (curRight == 4'd0) ? 16'hFFFF : ((16'd1 << curRight) - 16'd1);
        nMask     = ((nSeg == '0) ? maskLeft : 16'hFFFF) &
                    ((nSeg == curLen) ? maskRight : 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= IDLE;
            x0Lo       <= '0;
            segBase    <= '0;
            y0Reg      <= '0;
            wReg       <= '0;
            hM1        <= '0;
            lenHM1     <= '0;
            rightPos   <= '0;
            segIdx     <= '0;
            lineIdx    <= '0;
            o_busy     <= 1'b0;
            o_reqValid <= 1'b0;
            o_reqSegX  <= '0;
            o_reqLine  <= '0;
            o_reqMask  <= '0;
            o_firstSeg <= 1'b0;
            o_lastSeg  <= 1'b0;
            o_lastLine <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        x0Lo    <= i_x0[3:0];
                        segBase <= i_x0[SEG_XBITS+3:4];
                        y0Reg   <= i_y0;
                        wReg    <= i_w;
                        // h == 2^LINE_BITS wraps the low bits to 0, so h-1 still lands on the top line.
                        hM1     <= i_h[LINE_BITS-1:0] - LINE_BITS'(1);
                        o_busy  <= 1'b1;
                        if (i_w == '0 || i_h == '0) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    lenHM1     <= lenSetup;
                    rightPos   <= rightSetup;
                    segIdx     <= '0;
                    lineIdx    <= '0;
                    o_reqValid <= 1'b1;
                    o_reqSegX  <= segBase;
                    o_reqLine  <= y0Reg;
                    o_reqMask  <= nMask;
                    o_firstSeg <= 1'b1;
                    o_lastSeg  <= (lenSetup == '0);
                    o_lastLine <= (hM1 == '0);
                    state      <= RUN;
                end
                RUN: begin
                    if (handshake) begin
                        if (finalSeg) begin
                            o_reqValid <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            segIdx     <= nSeg;
                            lineIdx    <= nLine;
                            o_reqSegX  <= segBase + nSeg[SEG_XBITS-1:0];
                            o_reqLine  <= y0Reg + nLine;
                            o_reqMask  <= nMask;
                            o_firstSeg <= (nSeg == '0);
                            o_lastSeg  <= (nSeg == lenHM1);
                            o_lastLine <= (nLine == hM1);
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
